button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_debounce.sv | 177 +++++++++++++++++
 tb/tb_button_debounce.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Two-channel pushbutton debouncer.
// Each active-low raw button is synchronized, debounced by a four-state FSM,
// and reported as a level plus one-cycle press/release/long-press pulses.
// All outputs are registered one cycle after the FSM state they reflect.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic button_on,
  input  logic button_off,
  output logic on_level,
  output logic off_level,
  output logic on_press,
  output logic off_press,
  output logic on_release,
  output logic off_release,
  output logic on_hold,
  output logic off_hold,
  output logic both_level
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0] w_raw;
  logic [1:0] w_level;
  logic [1:0] w_press;
  logic [1:0] w_release;
  logic [1:0] w_hold;

  assign w_raw = {button_off, button_on};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic            r_sync1;
    logic            r_sync2;
    logic            w_sp;
    state_t          r_state;
    state_t          w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic            r_held;
    logic            w_held_nxt;
    logic            w_level_nxt;
    logic            r_level;
    logic            r_press;
    logic            r_release;
    logic            r_held_seen;
    logic            r_hold;

    // Two-flop synchronizer; flops idle at 1 (button released).
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync1 <= 1'b1;
        r_sync2 <= 1'b1;
      end else begin
        r_sync1 <= w_raw[g];
        r_sync2 <= r_sync1;
      end
    end

    assign w_sp = ~r_sync2;

    // FSM state, counter and once-per-press hold flag.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_held  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_held  <= w_held_nxt;
      end
    end

    // Next-state logic. r_held survives a RELEASE_WAIT->PRESSED bounce so a
    // single debounced press can never produce a second hold pulse.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_held_nxt  = r_held;
      case (r_state)
        IDLE: begin
          w_held_nxt = 1'b0;
          if (w_sp) begin
            w_state_nxt = PRESS_WAIT;
            w_cnt_nxt   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!w_sp) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DEB_LAST) begin
            w_state_nxt = PRESSED;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!w_sp) begin
            w_state_nxt = RELEASE_WAIT;
            w_cnt_nxt   = '0;
          end else if (r_cnt == HOLD_LAST) begin
            w_held_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (w_sp) begin
            w_state_nxt = PRESSED;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DEB_LAST) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_held_nxt  = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_held_nxt  = 1'b0;
        end
      endcase
    end

    assign w_level_nxt = (r_state == PRESSED) || (r_state == RELEASE_WAIT);

    // Registered level and edge pulses derived from the FSM state.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_level     <= 1'b0;
        r_press     <= 1'b0;
        r_release   <= 1'b0;
        r_held_seen <= 1'b0;
        r_hold      <= 1'b0;
      end else begin
        r_level     <= w_level_nxt;
        r_press     <= w_level_nxt & ~r_level;
        r_release   <= ~w_level_nxt & r_level;
        r_held_seen <= r_held;
        r_hold      <= r_held & ~r_held_seen;
      end
    end

    assign w_level[g]   = r_level;
    assign w_press[g]   = r_press;
    assign w_release[g] = r_release;
    assign w_hold[g]    = r_hold;
  end

  assign on_level    = w_level[0];
  assign off_level   = w_level[1];
  assign on_press    = w_press[0];
  assign off_press   = w_press[1];
  assign on_release  = w_release[0];
  assign off_release = w_release[1];
  assign on_hold     = w_hold[0];
  assign off_hold    = w_hold[1];
  assign both_level  = w_level[0] & w_level[1];

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
// Inputs change and outputs are sampled 1 time unit after each rising edge;
// "edge e" counts rising edges from the first edge that samples the new input.
module tb_button_debounce;

  logic clk = 1'b0;
  logic rst;
  logic button_on;
  logic button_off;
  logic on_level, off_level, on_press, off_press;
  logic on_release, off_release, on_hold, off_hold, both_level;

  int unsigned checks = 0;
  int unsigned errors = 0;

  button_debounce #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .button_on  (button_on),
    .button_off (button_off),
    .on_level   (on_level),
    .off_level  (off_level),
    .on_press   (on_press),
    .off_press  (off_press),
    .on_release (on_release),
    .off_release(off_release),
    .on_hold    (on_hold),
    .off_hold   (off_hold),
    .both_level (both_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_on(input string t, input int e,
                        input logic lv, input logic pr, input logic rl, input logic hd);
    chk($sformatf("%s_e%0d_on_level", t, e),   on_level,   lv);
    chk($sformatf("%s_e%0d_on_press", t, e),   on_press,   pr);
    chk($sformatf("%s_e%0d_on_release", t, e), on_release, rl);
    chk($sformatf("%s_e%0d_on_hold", t, e),    on_hold,    hd);
  endtask

  task automatic chk_all_zero(input string t);
    chk({t, "_on_level"},    on_level,    1'b0);
    chk({t, "_off_level"},   off_level,   1'b0);
    chk({t, "_on_press"},    on_press,    1'b0);
    chk({t, "_off_press"},   off_press,   1'b0);
    chk({t, "_on_release"},  on_release,  1'b0);
    chk({t, "_off_release"}, off_release, 1'b0);
    chk({t, "_on_hold"},     on_hold,     1'b0);
    chk({t, "_off_hold"},    off_hold,    1'b0);
    chk({t, "_both_level"},  both_level,  1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    button_on  = 1'b1;
    button_off = 1'b1;
    #2;
    chk_all_zero("reset_async");
    step();
    step();
    chk_all_zero("reset_clocked");
    rst = 1'b0;
    step();
    step();
    step();
    chk_all_zero("idle");

    // Clean press held 20 edges: press at 7, hold at 17, release at 27.
    button_on = 1'b0;
    for (int e = 0; e <= 28; e++) begin
      step();
      chk_on("long", e, (e >= 7 && e < 27), (e == 7), (e == 27), (e == 17));
      chk($sformatf("long_e%0d_off_level", e), off_level, 1'b0);
      if (e == 19) button_on = 1'b1;
    end
    repeat (4) step();

    // Bounce: low 3 edges, high 3 edges, five times.
    for (int r = 0; r < 5; r++) begin
      button_on = 1'b0;
      for (int k = 0; k < 3; k++) begin
        step();
        chk_on($sformatf("bounce%0d_lo", r), k, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      button_on = 1'b1;
      for (int k = 0; k < 3; k++) begin
        step();
        chk_on($sformatf("bounce%0d_hi", r), k, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    repeat (6) step();
    chk_on("bounce_end", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Release glitch of 2 edges: no release, hold count restarts (hold at 26).
    button_on = 1'b0;
    for (int e = 0; e <= 36; e++) begin
      step();
      chk_on("glitch", e, (e >= 7 && e < 35), (e == 7), (e == 35), (e == 26));
      if (e == 10) button_on = 1'b1;
      if (e == 12) button_on = 1'b0;
      if (e == 27) button_on = 1'b1;
    end
    repeat (4) step();

    // Both buttons fall together.
    button_on  = 1'b0;
    button_off = 1'b0;
    for (int e = 0; e <= 8; e++) begin
      step();
      chk($sformatf("both_e%0d_on_press", e),   on_press,   (e == 7));
      chk($sformatf("both_e%0d_off_press", e),  off_press,  (e == 7));
      chk($sformatf("both_e%0d_off_level", e),  off_level,  (e >= 7));
      chk($sformatf("both_e%0d_both_level", e), both_level, (e >= 7));
    end
    button_on = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      step();
      chk($sformatf("bothrel_e%0d_on_release", e),  on_release,  (e == 7));
      chk($sformatf("bothrel_e%0d_off_release", e), off_release, 1'b0);
      chk($sformatf("bothrel_e%0d_both_level", e),  both_level,  (e < 7));
      chk($sformatf("bothrel_e%0d_off_level", e),   off_level,   1'b1);
    end
    button_off = 1'b1;
    repeat (10) step();
    chk_all_zero("both_end");

    // Reset mid-press with button held.
    button_on = 1'b0;
    repeat (9) step();
    chk("pre_rst_on_level", on_level, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("mid_rst_async");
    for (int e = 0; e < 3; e++) begin
      step();
      chk_all_zero($sformatf("mid_rst_e%0d", e));
    end
    rst = 1'b0;
    for (int e = 0; e <= 8; e++) begin
      step();
      chk_on("post_rst", e, (e >= 7), (e == 7), 1'b0, 1'b0);
    end
    button_on = 1'b1;
    repeat (12) step();
    chk_all_zero("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
